// File: rtl/bayer_demosaic_stream_if.sv
// Pixel-path bundle for bayer_demosaic_stream: raw input stream, RGB output stream and markers.
// out_luma exists only when DEMOSAIC_LUMA_EN is defined.
interface bayer_demosaic_stream_if #(
  parameter int DATA_W = 8
);
  logic [1:0]          sensor_pattern;
  logic [DATA_W-1:0]   in_pixel;
  logic                in_valid;
  logic                in_sof;
  logic                in_ready;
  logic [3*DATA_W-1:0] out_pixel;
  logic                out_valid;
  logic                out_ready;
  logic                out_sof;
  logic                out_eol;
  logic                sof_err;
`ifdef DEMOSAIC_LUMA_EN
  logic [DATA_W-1:0]   out_luma;

  modport master (
    output sensor_pattern, in_pixel, in_valid, in_sof, out_ready,
    input  in_ready, out_pixel, out_valid, out_sof, out_eol, sof_err, out_luma
  );
  modport slave (
    input  sensor_pattern, in_pixel, in_valid, in_sof, out_ready,
    output in_ready, out_pixel, out_valid, out_sof, out_eol, sof_err, out_luma
  );
`else
  modport master (
    output sensor_pattern, in_pixel, in_valid, in_sof, out_ready,
    input  in_ready, out_pixel, out_valid, out_sof, out_eol, sof_err
  );
  modport slave (
    input  sensor_pattern, in_pixel, in_valid, in_sof, out_ready,
    output in_ready, out_pixel, out_valid, out_sof, out_eol, sof_err
  );
`endif
endinterface

// File: rtl/bayer_demosaic_stream.sv
// Streaming Bayer-to-RGB demosaic: 2x2 window (R, rounded mean of both G, B) over one line buffer.
// Define DEMOSAIC_LUMA_EN to add a registered out_luma = (77R + 150G + 29B) >> 8.
module bayer_demosaic_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input logic clk,
  input logic reset,
  bayer_demosaic_stream_if.slave bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1'b1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1'b1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
    return sum[DATA_W:1];
  endfunction

`ifdef DEMOSAIC_LUMA_EN
  function automatic logic [DATA_W-1:0] luma(input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] g,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W+7:0] sum;
    sum = (DATA_W+8)'(r) * (DATA_W+8)'(8'd77) + (DATA_W+8)'(g) * (DATA_W+8)'(8'd150)
        + (DATA_W+8)'(b) * (DATA_W+8)'(8'd29);
    return sum[DATA_W+7:8];
  endfunction

  logic [DATA_W-1:0] luma_r;
`endif

  logic [DATA_W-1:0]   line_buf [IMG_W];
  logic [COL_W-1:0]    col_r;
  logic [ROW_W-1:0]    row_r;
  logic [1:0]          pattern_r;
  logic [DATA_W-1:0]   up_r;
  logic [DATA_W-1:0]   cur_r;
  logic                out_valid_r;
  logic [3*DATA_W-1:0] out_pixel_r;
  logic                out_sof_r;
  logic                out_eol_r;
  logic                sof_err_r;

  logic                in_ready_s;
  logic                accept_s;
  logic                at_origin_s;
  logic                emit_s;
  logic [COL_W-1:0]    eff_col_s;
  logic [ROW_W-1:0]    eff_row_s;
  logic [1:0]          phase_s;
  logic [DATA_W-1:0]   win_u_s;
  logic [DATA_W-1:0]   red_s;
  logic [DATA_W-1:0]   blue_s;
  logic [DATA_W-1:0]   ga_s;
  logic [DATA_W-1:0]   gb_s;
  logic [DATA_W-1:0]   green_s;

  assign in_ready_s = !out_valid_r || bus.out_ready;

  // Window as it stands after this accept: up_left=up_r, up=line buffer, left=cur_r, cur=in_pixel.
  // An in_sof pixel is always handled as position (0,0).
  always_comb begin
    accept_s    = bus.in_valid && in_ready_s;
    at_origin_s = (col_r == COL_ZERO) && (row_r == ROW_ZERO);
    if (bus.in_sof) begin
      eff_col_s = COL_ZERO;
      eff_row_s = ROW_ZERO;
    end else begin
      eff_col_s = col_r;
      eff_row_s = row_r;
    end
    emit_s  = accept_s && (eff_col_s != COL_ZERO) && (eff_row_s != ROW_ZERO);
    phase_s = pattern_r ^ {~eff_row_s[0], ~eff_col_s[0]};
    win_u_s = line_buf[eff_col_s];
    case (phase_s)
      2'b00: begin red_s = up_r;    ga_s = win_u_s; gb_s = cur_r;        blue_s = bus.in_pixel; end
      2'b01: begin red_s = win_u_s; ga_s = up_r;    gb_s = bus.in_pixel; blue_s = cur_r;        end
      2'b10: begin red_s = cur_r;   ga_s = up_r;    gb_s = bus.in_pixel; blue_s = win_u_s;      end
      default: begin red_s = bus.in_pixel; ga_s = win_u_s; gb_s = cur_r; blue_s = up_r;         end
    endcase
    green_s = avg2(ga_s, gb_s);
  end

  // Previous-row storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_buf[eff_col_s] <= bus.in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_r     <= COL_ZERO;
      row_r     <= ROW_ZERO;
      pattern_r <= 2'b00;
      up_r      <= {DATA_W{1'b0}};
      cur_r     <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      if (bus.in_sof) begin
        pattern_r <= bus.sensor_pattern;
      end
      up_r  <= win_u_s;
      cur_r <= bus.in_pixel;
      if (eff_col_s == COL_LAST) begin
        col_r <= COL_ZERO;
        row_r <= (eff_row_s == ROW_LAST) ? ROW_ZERO : eff_row_s + ROW_ONE;
      end else begin
        col_r <= eff_col_s + COL_ONE;
        row_r <= eff_row_s;
      end
    end
  end

  // Single output register: reloads whenever it is empty or being drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_pixel_r <= {(3*DATA_W){1'b0}};
      out_sof_r   <= 1'b0;
      out_eol_r   <= 1'b0;
      sof_err_r   <= 1'b0;
`ifdef DEMOSAIC_LUMA_EN
      luma_r      <= {DATA_W{1'b0}};
`endif
    end else begin
      sof_err_r <= accept_s && bus.in_sof && !at_origin_s;
      if (in_ready_s) begin
        out_valid_r <= emit_s;
        if (emit_s) begin
          out_pixel_r <= {red_s, green_s, blue_s};
          out_sof_r   <= (eff_row_s == ROW_ONE) && (eff_col_s == COL_ONE);
          out_eol_r   <= (eff_col_s == COL_LAST);
`ifdef DEMOSAIC_LUMA_EN
          luma_r      <= luma(red_s, green_s, blue_s);
`endif
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_pixel = out_pixel_r;
  assign bus.out_sof   = out_sof_r;
  assign bus.out_eol   = out_eol_r;
  assign bus.sof_err   = sof_err_r;
`ifdef DEMOSAIC_LUMA_EN
  assign bus.out_luma  = luma_r;
`endif

endmodule

// File: tb/tb_bayer_demosaic_stream.sv
// Scoreboard bench: 2x2 and 4x3 geometries, all CFA phases, backpressure, sof_err and mid-frame reset.
module tb_bayer_demosaic_stream;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  bayer_demosaic_stream_if #(.DATA_W(8)) bus_a ();
  bayer_demosaic_stream_if #(.DATA_W(8)) bus_b ();

  bayer_demosaic_stream #(.DATA_W(8), .IMG_W(2), .IMG_H(2)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  bayer_demosaic_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(3)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  typedef struct packed {
    logic [23:0] pix;
    logic        sof;
    logic        eol;
    logic        luma_chk;
    logic [7:0]  luma;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;
  int checks = 0;
  int errors = 0;
  int sof_err_a = 0;
  int sof_err_b = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void push_a(input logic [23:0] pix, input logic lchk, input logic [7:0] lum);
    q_a.push_back('{pix: pix, sof: 1'b1, eol: 1'b1, luma_chk: lchk, luma: lum});
  endfunction

  function automatic void push_b(input logic [23:0] pix, input logic sof, input logic eol);
    q_b.push_back('{pix: pix, sof: sof, eol: eol, luma_chk: 1'b0, luma: 8'h00});
  endfunction

  // Hand-computed outputs of the 4x3 ramp 0..11 with RGGB latched.
  function automatic void push_ramp_b();
    push_b(24'h000305, 1'b1, 1'b0);
    push_b(24'h020405, 1'b0, 1'b0);
    push_b(24'h020507, 1'b0, 1'b1);
    push_b(24'h080705, 1'b0, 1'b0);
    push_b(24'h0A0805, 1'b0, 1'b0);
    push_b(24'h0A0907, 1'b0, 1'b1);
  endfunction

  always @(negedge clk) begin
    if (!rst_a && bus_a.out_valid && bus_a.out_ready) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_output actual=%06h required=none", bus_a.out_pixel);
      end else begin
        e_a = q_a.pop_front();
        check("a_pixel", 32'(bus_a.out_pixel), 32'(e_a.pix));
        check("a_sof", 32'(bus_a.out_sof), 32'(e_a.sof));
        check("a_eol", 32'(bus_a.out_eol), 32'(e_a.eol));
`ifdef DEMOSAIC_LUMA_EN
        if (e_a.luma_chk) check("a_luma", 32'(bus_a.out_luma), 32'(e_a.luma));
`endif
      end
    end
    if (bus_a.sof_err === 1'b1) sof_err_a++;
  end

  always @(negedge clk) begin
    if (!rst_b && bus_b.out_valid && bus_b.out_ready) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_output actual=%06h required=none", bus_b.out_pixel);
      end else begin
        e_b = q_b.pop_front();
        check("b_pixel", 32'(bus_b.out_pixel), 32'(e_b.pix));
        check("b_sof", 32'(bus_b.out_sof), 32'(e_b.sof));
        check("b_eol", 32'(bus_b.out_eol), 32'(e_b.eol));
      end
    end
    if (bus_b.sof_err === 1'b1) sof_err_b++;
  end

  // Present one pixel and return at posedge+1 of the cycle it was accepted.
  task automatic send(input bit b, input logic [7:0] p, input logic s);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    if (b) begin
      bus_b.in_pixel = p; bus_b.in_sof = s; bus_b.in_valid = 1'b1;
    end else begin
      bus_a.in_pixel = p; bus_a.in_sof = s; bus_a.in_valid = 1'b1;
    end
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = b ? bus_b.in_ready : bus_a.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept bus=%0d", b);
    end
  endtask

  task automatic idle(input bit b);
    if (b) begin
      bus_b.in_valid = 1'b0; bus_b.in_sof = 1'b0;
    end else begin
      bus_a.in_valid = 1'b0; bus_a.in_sof = 1'b0;
    end
  endtask

  task automatic frame_a(input logic [1:0] pat, input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3, input logic sof);
    bus_a.sensor_pattern = pat;
    send(1'b0, p0, sof);
    send(1'b0, p1, 1'b0);
    send(1'b0, p2, 1'b0);
    check("a_valid_before_last", 32'(bus_a.out_valid), 32'd0);
    send(1'b0, p3, 1'b0);
    idle(1'b0);
    check("a_valid_after_last", 32'(bus_a.out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_sof = 1'b0; bus_a.in_pixel = 8'h00;
    bus_a.sensor_pattern = 2'b00; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_sof = 1'b0; bus_b.in_pixel = 8'h00;
    bus_b.sensor_pattern = 2'b00; bus_b.out_ready = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("a_rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("a_rst_pixel", 32'(bus_a.out_pixel), 32'd0);
    check("a_rst_sof_eol", 32'({bus_a.out_sof, bus_a.out_eol, bus_a.sof_err}), 32'd0);
    check("a_rst_ready", 32'(bus_a.in_ready), 32'd1);
    check("b_rst_valid", 32'(bus_b.out_valid), 32'd0);
    check("b_rst_pixel", 32'(bus_b.out_pixel), 32'd0);
    @(posedge clk);
    #1;

    // 2x2 frames: every CFA phase, G rounding carry, auto-wrap without in_sof, luma vectors.
    push_a(24'hFF00FF, 1'b0, 8'h00); frame_a(2'b00, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1);
    push_a(24'hFF00FF, 1'b0, 8'h00); frame_a(2'b11, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1);
    push_a(24'h202830, 1'b0, 8'h00); frame_a(2'b01, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    push_a(24'h302820, 1'b0, 8'h00); frame_a(2'b10, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    push_a(24'hFFFF00, 1'b0, 8'h00); frame_a(2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h00, 1'b1);
    push_a(24'h102840, 1'b0, 8'h00); frame_a(2'b11, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
    push_a(24'hFFFFFF, 1'b1, 8'hFF); frame_a(2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    push_a(24'hFF0000, 1'b1, 8'h4C); frame_a(2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // 4x3 ramp with a 5-cycle downstream stall once (1,1) is pending.
    push_ramp_b();
    bus_b.sensor_pattern = 2'b00;
    for (int i = 0; i < 6; i++) send(1'b1, 8'(i), i == 0);
    bus_b.out_ready = 1'b0;
    bus_b.in_pixel = 8'd6; bus_b.in_sof = 1'b0; bus_b.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b_stall_ready", 32'(bus_b.in_ready), 32'd0);
      check("b_stall_valid", 32'(bus_b.out_valid), 32'd1);
      if (q_b.size() > 0) check("b_stall_pixel", 32'(bus_b.out_pixel), 32'(q_b[0].pix));
    end
    @(posedge clk);
    #1;
    bus_b.out_ready = 1'b1;
    for (int i = 6; i < 12; i++) send(1'b1, 8'(i), 1'b0);
    idle(1'b1);
    repeat (3) @(posedge clk);
    #1;

    // in_sof at (1,2): restart there, no output for that pixel, one sof_err pulse.
    push_b(24'h000305, 1'b1, 1'b0);
    push_ramp_b();
    for (int i = 0; i < 6; i++) send(1'b1, 8'(i), i == 0);
    send(1'b1, 8'd0, 1'b1);
    for (int i = 1; i < 12; i++) send(1'b1, 8'(i), 1'b0);
    idle(1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Mid-frame reset with a pending output; the next frame has no in_sof so reset pattern 00 applies.
    bus_b.out_ready = 1'b0;
    bus_b.sensor_pattern = 2'b11;
    for (int i = 0; i < 6; i++) send(1'b1, 8'(i), i == 0);
    idle(1'b1);
    check("b_pre_reset_valid", 32'(bus_b.out_valid), 32'd1);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    check("b_post_reset_valid", 32'(bus_b.out_valid), 32'd0);
    check("b_post_reset_pixel", 32'(bus_b.out_pixel), 32'd0);
    check("b_post_reset_flags", 32'({bus_b.out_sof, bus_b.out_eol, bus_b.sof_err}), 32'd0);
    bus_b.out_ready = 1'b1;
    push_ramp_b();
    for (int i = 0; i < 12; i++) send(1'b1, 8'(i), 1'b0);
    idle(1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);

    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    check("a_sof_err_pulses", 32'(sof_err_a), 32'd0);
    check("b_sof_err_pulses", 32'(sof_err_b), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
